// File: rtl/tl_ctrl_pkg.sv
// Shared types for the intersection controller: per-direction light codes,
// controller phases and the round-robin direction helper.
package tl_ctrl_pkg;

  typedef enum logic [1:0] {
    L_RED    = 2'b00,
    L_YELLOW = 2'b01,
    L_GREEN  = 2'b10,
    L_OFF    = 2'b11
  } light_t;

  typedef enum logic [2:0] {
    ALLRED    = 3'd0,
    GREEN     = 3'd1,
    YELLOW    = 3'd2,
    EMG_GREEN = 3'd3,
    FLASH     = 3'd4
  } phase_t;

  function automatic int unsigned next_dir(input int unsigned dir, input int unsigned n);
    return (dir + 1 >= n) ? 0 : dir + 1;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Bundle between the intersection top level and the light controller.
interface traffic_light_ctrl_if #(
  parameter int N_DIR = 4
);
  import tl_ctrl_pkg::*;

  localparam int DIR_W = $clog2(N_DIR);

  // No valid/ready: every input is a level sampled on each rising clk edge,
  // every output is registered and meaningful on every cycle.
  logic                 en;
  logic [N_DIR-1:0]     ped_req;
  logic                 emergency;
  logic [DIR_W-1:0]     emg_dir;
  light_t [N_DIR-1:0]   light;
  logic [DIR_W-1:0]     active_dir;
  logic [N_DIR-1:0]     ped_walk;
  phase_t               phase;

  modport master (
    output en, ped_req, emergency, emg_dir,
    input  light, active_dir, ped_walk, phase
  );

  modport slave (
    input  en, ped_req, emergency, emg_dir,
    output light, active_dir, ped_walk, phase
  );

endinterface

// File: rtl/tl_phase_timer.sv
// Loadable phase down-counter: load wins over freeze, counting stops at zero.
module tl_phase_timer #(
  parameter int             CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             freeze,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (!freeze && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// N-way round-robin light controller with pedestrian walk, emergency
// preemption and flash mode. All outputs come straight from registers.
module traffic_light_ctrl
  import tl_ctrl_pkg::*;
#(
  parameter int N_DIR      = 4,
  parameter int CNT_W      = 8,
  parameter int GREEN_CYC  = 20,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 2,
  parameter int FLASH_CYC  = 5
) (
  input  logic                 clk,
  input  logic                 asyn_reset,
  traffic_light_ctrl_if.slave  bus
);

  localparam int DIR_W = $clog2(N_DIR);

  phase_t              phase_q, phase_n;
  logic [DIR_W-1:0]    dir_q, dir_n;
  logic                flash_q, flash_n;
  logic [N_DIR-1:0]    pend_q, pend_n;
  logic [N_DIR-1:0]    walk_q, walk_n;
  light_t [N_DIR-1:0]  light_q, light_n;

  logic                t_load, t_freeze, t_zero;
  logic [CNT_W-1:0]    t_load_val;

  tl_phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(ALLRED_CYC - 1))
  ) u_timer (
    .clk      (clk),
    .rst      (asyn_reset),
    .load     (t_load),
    .freeze   (t_freeze),
    .load_val (t_load_val),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      phase_q <= ALLRED;
      dir_q   <= '0;
      flash_q <= 1'b0;
      pend_q  <= '0;
      walk_q  <= '0;
      for (int i = 0; i < N_DIR; i++) light_q[i] <= L_RED;
    end else begin
      phase_q <= phase_n;
      dir_q   <= dir_n;
      flash_q <= flash_n;
      pend_q  <= pend_n;
      walk_q  <= walk_n;
      light_q <= light_n;
    end
  end

  always_comb begin
    phase_n    = phase_q;
    dir_n      = dir_q;
    flash_n    = flash_q;
    t_load     = 1'b0;
    t_freeze   = 1'b0;
    t_load_val = '0;
    pend_n     = pend_q | bus.ped_req;
    if (!bus.en) begin
      // Flash blinks on its own timer; entry always starts on the yellow half.
      if (phase_q != FLASH) begin
        phase_n    = FLASH;
        flash_n    = 1'b0;
        t_load     = 1'b1;
        t_load_val = CNT_W'(FLASH_CYC - 1);
      end else if (t_zero) begin
        flash_n    = ~flash_q;
        t_load     = 1'b1;
        t_load_val = CNT_W'(FLASH_CYC - 1);
      end
    end else begin
      case (phase_q)
        ALLRED: begin
          if (t_zero) begin
            t_load = 1'b1;
            if (bus.emergency) begin
              phase_n = EMG_GREEN;
              dir_n   = bus.emg_dir;
            end else begin
              phase_n    = GREEN;
              t_load_val = CNT_W'(GREEN_CYC - 1);
            end
          end
        end
        GREEN: begin
          if (bus.emergency && bus.emg_dir == dir_q) begin
            phase_n = EMG_GREEN;
            t_load  = 1'b1;
          end else if (bus.emergency || t_zero) begin
            phase_n    = YELLOW;
            t_load     = 1'b1;
            t_load_val = CNT_W'(YELLOW_CYC - 1);
          end
        end
        YELLOW: begin
          if (t_zero) begin
            phase_n    = ALLRED;
            dir_n      = DIR_W'(next_dir(32'(dir_q), N_DIR));
            t_load     = 1'b1;
            t_load_val = CNT_W'(ALLRED_CYC - 1);
          end
        end
        EMG_GREEN: begin
          if (!bus.emergency) begin
            phase_n    = YELLOW;
            t_load     = 1'b1;
            t_load_val = CNT_W'(YELLOW_CYC - 1);
          end else begin
            t_freeze = 1'b1;
          end
        end
        default: begin
          phase_n    = ALLRED;
          dir_n      = '0;
          t_load     = 1'b1;
          t_load_val = CNT_W'(ALLRED_CYC - 1);
        end
      endcase
    end
    // A press on the green-entry edge itself is kept for the next green.
    if (phase_n == GREEN && phase_q != GREEN) pend_n[dir_n] = bus.ped_req[dir_n];
  end

  always_comb begin
    walk_n = '0;
    if (phase_n == GREEN) begin
      if (phase_q == GREEN) walk_n = walk_q;
      else                  walk_n[dir_n] = pend_q[dir_n];
    end
    for (int i = 0; i < N_DIR; i++) begin
      light_n[i] = L_RED;
      case (phase_n)
        GREEN, EMG_GREEN: if (DIR_W'(i) == dir_n) light_n[i] = L_GREEN;
        YELLOW:           if (DIR_W'(i) == dir_n) light_n[i] = L_YELLOW;
        FLASH:            light_n[i] = flash_n ? L_OFF : L_YELLOW;
        default:          light_n[i] = L_RED;
      endcase
    end
  end

  assign bus.light      = light_q;
  assign bus.active_dir = dir_q;
  assign bus.ped_walk   = walk_q;
  assign bus.phase      = phase_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench: per-cycle expected observations are queued by the driver
// and checked by a negedge monitor.
module tb_traffic_light_ctrl;
  import tl_ctrl_pkg::*;

  logic clk = 1'b0;
  logic asyn_reset = 1'b1;

  always #5 clk = ~clk;

  traffic_light_ctrl_if #(.N_DIR(4)) bus ();

  traffic_light_ctrl #(
    .N_DIR(4), .CNT_W(8), .GREEN_CYC(6), .YELLOW_CYC(2), .ALLRED_CYC(1), .FLASH_CYC(3)
  ) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .bus        (bus)
  );

  typedef struct {
    phase_t     ph;
    logic [1:0] dir;
    logic [3:0] walk;
    int         len;
    bit         off;
  } seg_t;

  typedef struct {
    int         cyc;
    logic       en;
    logic [3:0] ped;
    logic       emg;
    logic [1:0] edir;
  } stim_t;

  seg_t         segs[$];
  stim_t        stims[$];
  logic [16:0]  exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;

  // Expected observation: {phase, active_dir, light[3..0], ped_walk}.
  function automatic logic [16:0] exp_vec(phase_t ph, logic [1:0] dir, logic [3:0] walk, bit off);
    logic [7:0] lv;
    logic [1:0] code;
    for (int i = 0; i < 4; i++) begin
      code = L_RED;
      case (ph)
        GREEN, EMG_GREEN: if (2'(i) == dir) code = L_GREEN;
        YELLOW:           if (2'(i) == dir) code = L_YELLOW;
        FLASH:            code = off ? L_OFF : L_YELLOW;
        default:          code = L_RED;
      endcase
      lv[2*i +: 2] = code;
    end
    return {ph, dir, lv, walk};
  endfunction

  task automatic check_now(string tag, logic [16:0] want);
    logic [16:0] got;
    got = {bus.phase, bus.active_dir, bus.light, bus.ped_walk};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s (immediate): got ph=%0d dir=%0d light=%h walk=%b, want ph=%0d dir=%0d light=%h walk=%b",
               tag, got[16:14], got[13:12], got[11:4], got[3:0],
               want[16:14], want[13:12], want[11:4], want[3:0]);
    end
  endtask

  task automatic add_seg(phase_t ph, int dir, logic [3:0] walk, int len, bit off = 1'b0);
    seg_t s;
    s.ph = ph; s.dir = 2'(dir); s.walk = walk; s.len = len; s.off = off;
    segs.push_back(s);
  endtask

  task automatic add_round(int dir, logic [3:0] walk);
    add_seg(GREEN, dir, walk, 6);
    add_seg(YELLOW, dir, 4'b0000, 2);
    add_seg(ALLRED, (dir + 1) % 4, 4'b0000, 1);
  endtask

  task automatic add_stim(int cyc, logic en, logic [3:0] ped, logic emg, logic [1:0] edir);
    stim_t s;
    s.cyc = cyc; s.en = en; s.ped = ped; s.emg = emg; s.edir = edir;
    stims.push_back(s);
  endtask

  // Called at posedge+1; the reset-state check lands on the following negedge.
  task automatic do_reset(string name);
    asyn_reset    = 1'b1;
    bus.en        = 1'b1;
    bus.ped_req   = 4'b0000;
    bus.emergency = 1'b0;
    bus.emg_dir   = 2'd0;
    #1;
    check_now($sformatf("%s reset", name), exp_vec(ALLRED, 2'd0, 4'b0000, 1'b0));
    exp_q.push_back(exp_vec(ALLRED, 2'd0, 4'b0000, 1'b0));
    tag_q.push_back($sformatf("%s reset", name));
    @(posedge clk);
    #1;
    asyn_reset = 1'b0;
  endtask

  task automatic run_scenario(string name);
    logic [16:0] v[$];
    foreach (segs[k])
      for (int j = 0; j < segs[k].len; j++)
        v.push_back(exp_vec(segs[k].ph, segs[k].dir, segs[k].walk, segs[k].off));
    do_reset(name);
    for (int c = 0; c < v.size(); c++) begin
      foreach (stims[k]) begin
        if (stims[k].cyc == c) begin
          bus.en        = stims[k].en;
          bus.ped_req   = stims[k].ped;
          bus.emergency = stims[k].emg;
          bus.emg_dir   = stims[k].edir;
        end
      end
      exp_q.push_back(v[c]);
      tag_q.push_back($sformatf("%s c=%0d", name, c));
      @(posedge clk);
      #1;
    end
    segs.delete();
    stims.delete();
  endtask

  always @(negedge clk) begin
    logic [16:0] got;
    logic [16:0] want;
    string       tag;
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      tag  = tag_q.pop_front();
      got  = {bus.phase, bus.active_dir, bus.light, bus.ped_walk};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got ph=%0d dir=%0d light=%h walk=%b, want ph=%0d dir=%0d light=%h walk=%b",
                 tag, got[16:14], got[13:12], got[11:4], got[3:0],
                 want[16:14], want[13:12], want[11:4], want[3:0]);
      end
    end
  end

  initial begin
    int wait_cyc;
    bus.en        = 1'b1;
    bus.ped_req   = 4'b0000;
    bus.emergency = 1'b0;
    bus.emg_dir   = 2'd0;
    @(posedge clk);
    #1;

    // Plain rotation: dir0 green 1-6, yellow 7-8, allred 9, ... dir0 again at 37.
    add_seg(ALLRED, 0, 4'b0000, 1);
    for (int d = 0; d < 4; d++) add_round(d, 4'b0000);
    add_seg(GREEN, 0, 4'b0000, 2);
    run_scenario("rotation");

    // Pedestrian: press at 3 walks on 19-24, press at 20 held for 55-60.
    add_stim(3, 1'b1, 4'b0100, 1'b0, 2'd0);
    add_stim(4, 1'b1, 4'b0000, 1'b0, 2'd0);
    add_stim(20, 1'b1, 4'b0100, 1'b0, 2'd0);
    add_stim(21, 1'b1, 4'b0000, 1'b0, 2'd0);
    add_seg(ALLRED, 0, 4'b0000, 1);
    add_round(0, 4'b0000);
    add_round(1, 4'b0000);
    add_round(2, 4'b0100);
    add_round(3, 4'b0000);
    add_round(0, 4'b0000);
    add_round(1, 4'b0000);
    add_seg(GREEN, 2, 4'b0100, 6);
    add_seg(YELLOW, 2, 4'b0000, 1);
    run_scenario("ped");

    // Preemption mid-green toward dir3; emg_dir change while held is ignored.
    add_stim(3, 1'b1, 4'b0000, 1'b1, 2'd3);
    add_stim(9, 1'b1, 4'b0000, 1'b1, 2'd1);
    add_stim(12, 1'b1, 4'b0000, 1'b0, 2'd1);
    add_seg(ALLRED, 0, 4'b0000, 1);
    add_seg(GREEN, 0, 4'b0000, 3);
    add_seg(YELLOW, 0, 4'b0000, 2);
    add_seg(ALLRED, 1, 4'b0000, 1);
    add_seg(EMG_GREEN, 3, 4'b0000, 6);
    add_seg(YELLOW, 3, 4'b0000, 2);
    add_seg(ALLRED, 0, 4'b0000, 1);
    add_seg(GREEN, 0, 4'b0000, 3);
    run_scenario("emg_mid");

    // Preemption of the direction already green: no yellow until release.
    add_stim(2, 1'b1, 4'b0000, 1'b1, 2'd0);
    add_stim(10, 1'b1, 4'b0000, 1'b0, 2'd0);
    add_seg(ALLRED, 0, 4'b0000, 1);
    add_seg(GREEN, 0, 4'b0000, 2);
    add_seg(EMG_GREEN, 0, 4'b0000, 8);
    add_seg(YELLOW, 0, 4'b0000, 2);
    add_seg(ALLRED, 1, 4'b0000, 1);
    add_seg(GREEN, 1, 4'b0000, 3);
    run_scenario("emg_own");

    // Flash from green; a press during flash survives to dir0's next green.
    add_stim(4, 1'b0, 4'b0000, 1'b0, 2'd0);
    add_stim(6, 1'b0, 4'b0001, 1'b0, 2'd0);
    add_stim(7, 1'b0, 4'b0000, 1'b0, 2'd0);
    add_stim(16, 1'b1, 4'b0000, 1'b0, 2'd0);
    add_seg(ALLRED, 0, 4'b0000, 1);
    add_seg(GREEN, 0, 4'b0000, 4);
    add_seg(FLASH, 0, 4'b0000, 3, 1'b0);
    add_seg(FLASH, 0, 4'b0000, 3, 1'b1);
    add_seg(FLASH, 0, 4'b0000, 3, 1'b0);
    add_seg(FLASH, 0, 4'b0000, 3, 1'b1);
    add_seg(ALLRED, 0, 4'b0000, 1);
    add_seg(GREEN, 0, 4'b0001, 6);
    add_seg(YELLOW, 0, 4'b0000, 1);
    run_scenario("flash");

    // Reset asserted mid-yellow must act before the next clock edge.
    add_seg(ALLRED, 0, 4'b0000, 1);
    add_seg(GREEN, 0, 4'b0000, 6);
    add_seg(YELLOW, 0, 4'b0000, 1);
    run_scenario("pre_async");
    do_reset("async_mid_yellow");

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected observations never checked after %0d cycles",
               exp_q.size(), wait_cyc);
    end

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
